// File: rtl/ddr_host_req_queue_pkg.sv
// Shared types for the DDR4 host request queue: request codes, address/data
// payloads, mode-register configuration and the RL/WL decode helpers.
package ddr_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    RD  = 3'd1,
    WR  = 3'd2,
    MRS = 3'd3
  } host_req_t;

  typedef struct packed {
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } host_address;

  typedef logic [7:0][63:0] write_data;

  typedef struct packed {
    host_req_t   req;
    host_address addr;
    write_data   data;
  } req_entry_t;

  typedef struct packed {
    logic [2:0] cl;
    logic [2:0] bl;
    logic [2:0] cwl;
    logic [1:0] al;
    logic       rd_pre;
    logic       wr_pre;
  } mrs_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_MRS
  } mrs_state_t;

  localparam mrs_cfg_t   MRS_DEFAULT = '0;
  localparam logic [5:0] LAT_DEFAULT = 6'd9;

  function automatic logic [5:0] cl_tck(input logic [2:0] code);
    return 6'd9 + {3'b000, code};
  endfunction

  function automatic logic [5:0] cwl_tck(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd9;
      3'd1:    return 6'd10;
      3'd2:    return 6'd11;
      3'd3:    return 6'd12;
      3'd4:    return 6'd14;
      3'd5:    return 6'd16;
      3'd6:    return 6'd18;
      default: return 6'd20;
    endcase
  endfunction

  // Additive latency is expressed relative to CL; code 3 behaves as off.
  function automatic logic [5:0] al_tck(input logic [1:0] al, input logic [5:0] cl_t);
    case (al)
      2'd1:    return cl_t - 6'd1;
      2'd2:    return cl_t - 6'd2;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] rl_tck(input mrs_cfg_t c);
    return cl_tck(c.cl) + al_tck(c.al, cl_tck(c.cl)) + {5'b00000, c.rd_pre};
  endfunction

  function automatic logic [5:0] wl_tck(input mrs_cfg_t c);
    return cwl_tck(c.cwl) + al_tck(c.al, cl_tck(c.cl)) + {5'b00000, c.wr_pre};
  endfunction

endpackage

// File: rtl/ddr_host_req_queue_if.sv
// Host request / command issue bundle. The queue is the slave; the host and
// command path together form the master side.
interface ddr_host_req_queue_if;
  import ddr_pkg::*;

  logic [2:0]  request;
  host_address log_addr;
  write_data   wr_data;
  logic        req_ready;
  logic        out_valid;
  host_req_t   out_request;
  host_address out_addr;
  write_data   out_wr_data;
  logic        cmd_rdy;

  modport master (
    output request, log_addr, wr_data, cmd_rdy,
    input  req_ready, out_valid, out_request, out_addr, out_wr_data
  );

  modport slave (
    input  request, log_addr, wr_data, cmd_rdy,
    output req_ready, out_valid, out_request, out_addr, out_wr_data
  );

endinterface

// File: rtl/ddr_host_req_queue_fifo.sv
// Request FIFO with a registered head entry: out_valid and the head payload
// come straight from flops, with a bypass when pushing into an empty queue.
module ddr_req_fifo
  import ddr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_entry_t       push_entry,
  input  logic             pop,
  output req_entry_t       head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  req_entry_t       mem_q [DEPTH];
  req_entry_t       head_q, head_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remain;

  // NOTE: every _d signal gets a default before any condition, so this block cannot infer a latch.
  always_comb begin
    remain   = count_q - CNT_W'(pop);
    count_d  = remain + CNT_W'(push);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    if (push && remain == '0) begin
      head_d = push_entry;
    end else if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: storage and head payload carry no reset; valid_q and count_q alone say what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
    head_q <= head_d;
  end

  assign head       = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/ddr_host_req_queue.sv
// Host-side front end of the DDR4 controller: queues RD/WR requests, serialises
// mode-register updates (drain, one MRS, apply config) and publishes RL/WL.
module ddr_host_req_queue
  import ddr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 CK_t,
  input  logic                 reset,
  ddr_host_req_queue_if.slave  bus,
  input  logic                 mrs_update,
  input  logic [2:0]           CL,
  input  logic [2:0]           BL,
  input  logic [2:0]           CWL,
  input  logic [1:0]           AL,
  input  logic                 RD_PRE,
  input  logic                 WR_PRE,
  output logic [2:0]           cfg_CL,
  output logic [2:0]           cfg_BL,
  output logic [2:0]           cfg_CWL,
  output logic [1:0]           cfg_AL,
  output logic                 cfg_RD_PRE,
  output logic                 cfg_WR_PRE,
  output logic [5:0]           rd_lat,
  output logic [5:0]           wr_lat,
  output logic                 busy,
  output logic [CNT_W-1:0]     count
);

  req_entry_t       push_entry, head;
  logic             push, pop, head_valid;
  logic [CNT_W-1:0] fifo_count;

  mrs_state_t state_q, state_d;
  logic       pend_mrs_q, pend_mrs_d;
  mrs_cfg_t   pend_cfg_q, pend_cfg_d, cfg_q, cfg_d, in_cfg;
  logic [5:0] rd_lat_q, rd_lat_d, wr_lat_q, wr_lat_d;

  ddr_req_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk        (CK_t),
    .rst        (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Host side accepts only RD/WR; the head never coexists with the MRS slot.
  always_comb begin
    bus.req_ready   = !reset && (fifo_count < CNT_W'(DEPTH)) && (state_q == ST_IDLE) && !pend_mrs_q;
    push            = bus.req_ready && (bus.request == RD || bus.request == WR);
    push_entry.req  = host_req_t'(bus.request);
    push_entry.addr = bus.log_addr;
    push_entry.data = (bus.request == WR) ? bus.wr_data : '0;
    pop             = head_valid && bus.cmd_rdy;

    bus.out_valid   = (state_q == ST_MRS) || head_valid;
    bus.out_request = (state_q == ST_MRS) ? MRS : head.req;
    bus.out_addr    = (state_q == ST_MRS) ? '0 : head.addr;
    bus.out_wr_data = (state_q == ST_MRS) ? '0 : head.data;
  end

  always_comb begin
    in_cfg     = '{cl: CL, bl: BL, cwl: CWL, al: AL, rd_pre: RD_PRE, wr_pre: WR_PRE};
    state_d    = state_q;
    pend_mrs_d = pend_mrs_q;
    pend_cfg_d = mrs_update ? in_cfg : pend_cfg_q;
    cfg_d      = cfg_q;
    rd_lat_d   = rd_lat_q;
    wr_lat_d   = wr_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (mrs_update) begin
          pend_mrs_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) state_d = ST_MRS;
      end
      ST_MRS: begin
        // An update arriving on the handshake cycle is the last write and wins.
        if (bus.cmd_rdy) begin
          cfg_d      = pend_cfg_d;
          rd_lat_d   = rl_tck(pend_cfg_d);
          wr_lat_d   = wl_tck(pend_cfg_d);
          pend_mrs_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_mrs_q <= 1'b0;
      pend_cfg_q <= MRS_DEFAULT;
      cfg_q      <= MRS_DEFAULT;
      rd_lat_q   <= LAT_DEFAULT;
      wr_lat_q   <= LAT_DEFAULT;
    end else begin
      state_q    <= state_d;
      pend_mrs_q <= pend_mrs_d;
      pend_cfg_q <= pend_cfg_d;
      cfg_q      <= cfg_d;
      rd_lat_q   <= rd_lat_d;
      wr_lat_q   <= wr_lat_d;
    end
  end

  assign cfg_CL     = cfg_q.cl;
  assign cfg_BL     = cfg_q.bl;
  assign cfg_CWL    = cfg_q.cwl;
  assign cfg_AL     = cfg_q.al;
  assign cfg_RD_PRE = cfg_q.rd_pre;
  assign cfg_WR_PRE = cfg_q.wr_pre;
  assign rd_lat     = rd_lat_q;
  assign wr_lat     = wr_lat_q;
  assign count      = fifo_count;
  assign busy       = (fifo_count != '0) || (state_q != ST_IDLE) || pend_mrs_q;

endmodule

// File: tb/tb_ddr_host_req_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// every cycle against a queue-based behavioural model of the request queue.
module tb_ddr_host_req_queue;
  import ddr_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             CK_t = 1'b0;
  logic             reset;
  logic             mrs_update;
  logic [2:0]       CL, BL, CWL;
  logic [1:0]       AL;
  logic             RD_PRE, WR_PRE;
  logic [2:0]       cfg_CL, cfg_BL, cfg_CWL;
  logic [1:0]       cfg_AL;
  logic             cfg_RD_PRE, cfg_WR_PRE;
  logic [5:0]       rd_lat, wr_lat;
  logic             busy;
  logic [CNT_W-1:0] count;

  ddr_host_req_queue_if bus ();

  ddr_host_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CK_t       (CK_t),
    .reset      (reset),
    .bus        (bus),
    .mrs_update (mrs_update),
    .CL         (CL),
    .BL         (BL),
    .CWL        (CWL),
    .AL         (AL),
    .RD_PRE     (RD_PRE),
    .WR_PRE     (WR_PRE),
    .cfg_CL     (cfg_CL),
    .cfg_BL     (cfg_BL),
    .cfg_CWL    (cfg_CWL),
    .cfg_AL     (cfg_AL),
    .cfg_RD_PRE (cfg_RD_PRE),
    .cfg_WR_PRE (cfg_WR_PRE),
    .rd_lat     (rd_lat),
    .wr_lat     (wr_lat),
    .busy       (busy),
    .count      (count)
  );

  always #5 CK_t = ~CK_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued requests, an outstanding MRS, and whether the MRS is on the bus.
  req_entry_t mq[$];
  bit         m_pending;
  bit         m_presenting;
  mrs_cfg_t   m_cfg, m_pend;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int ref_cwl(input int code);
    int tab[8] = '{9, 10, 11, 12, 14, 16, 18, 20};
    return tab[code];
  endfunction

  function automatic int ref_al(input mrs_cfg_t c);
    int cl = 9 + int'(c.cl);
    if (c.al == 2'd1) return cl - 1;
    if (c.al == 2'd2) return cl - 2;
    return 0;
  endfunction

  function automatic int ref_rl(input mrs_cfg_t c);
    return 9 + int'(c.cl) + ref_al(c) + int'(c.rd_pre);
  endfunction

  function automatic int ref_wl(input mrs_cfg_t c);
    return ref_cwl(int'(c.cwl)) + ref_al(c) + int'(c.wr_pre);
  endfunction

  function automatic mrs_cfg_t cur_cfg();
    return '{cl: CL, bl: BL, cwl: CWL, al: AL, rd_pre: RD_PRE, wr_pre: WR_PRE};
  endfunction

  function automatic bit model_ready();
    return !reset && mq.size() < DEPTH && !m_pending && !m_presenting;
  endfunction

  function automatic write_data rand_data();
    write_data d;
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    return d;
  endfunction

  function automatic host_address rand_addr();
    logic [31:0] r = $urandom;
    return r[29:0];
  endfunction

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = m_presenting || mq.size() != 0;
    check("req_ready", bus.req_ready, model_ready());
    check("out_valid", bus.out_valid, exp_valid);
    check("count", count, mq.size());
    check("busy", busy, mq.size() != 0 || m_pending || m_presenting);
    check("cfg", {cfg_CL, cfg_BL, cfg_CWL, cfg_AL, cfg_RD_PRE, cfg_WR_PRE}, m_cfg);
    check("rd_lat", rd_lat, ref_rl(m_cfg));
    check("wr_lat", wr_lat, ref_wl(m_cfg));
    if (m_presenting) begin
      check("out_request", bus.out_request, MRS);
      check("out_addr", bus.out_addr, 0);
      check("out_wr_data", bus.out_wr_data, 0);
    end else if (exp_valid) begin
      check("out_request", bus.out_request, mq[0].req);
      check("out_addr", bus.out_addr, mq[0].addr);
      check("out_wr_data", bus.out_wr_data, mq[0].data);
    end
  endtask

  task automatic model_update();
    bit         acc, take;
    int         q0;
    req_entry_t e;
    if (reset) begin
      mq.delete();
      m_pending    = 1'b0;
      m_presenting = 1'b0;
      m_cfg        = '0;
      m_pend       = '0;
    end else begin
      acc  = model_ready() && (bus.request == 3'd1 || bus.request == 3'd2);
      take = !m_presenting && mq.size() != 0 && bus.cmd_rdy;
      q0   = mq.size();
      if (take) void'(mq.pop_front());
      if (acc) begin
        e.req  = host_req_t'(bus.request);
        e.addr = bus.log_addr;
        e.data = (bus.request == 3'd2) ? bus.wr_data : '0;
        mq.push_back(e);
      end
      if (mrs_update) m_pend = cur_cfg();
      if (m_presenting) begin
        if (bus.cmd_rdy) begin
          m_cfg        = m_pend;
          m_presenting = 1'b0;
          m_pending    = 1'b0;
        end
      end else if (m_pending) begin
        if (q0 == 0) m_presenting = 1'b1;
      end else if (mrs_update) begin
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge CK_t);
    compare_outputs();
    @(posedge CK_t);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    bus.request  = 3'd0;
    bus.log_addr = '0;
    bus.wr_data  = '0;
    bus.cmd_rdy  = 1'b0;
    mrs_update   = 1'b0;
    {CL, BL, CWL, AL, RD_PRE, WR_PRE} = '0;
  endtask

  task automatic set_cfg(input logic [2:0] cl, input logic [2:0] cwl, input logic [1:0] al,
                         input logic rdp, input logic wrp);
    CL = cl; BL = 3'd0; CWL = cwl; AL = al; RD_PRE = rdp; WR_PRE = wrp;
  endtask

  task automatic push_req(input logic [2:0] code, input host_address a, input write_data d);
    bus.request  = code;
    bus.log_addr = a;
    bus.wr_data  = d;
    step();
    bus.request  = 3'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    write_data   d[9];
    host_address a[9];
    logic [8:0]  ord;
    int          k, n_iss, n_mrs;
    bit          held, take;

    idle_in();
    m_pending = 1'b0; m_presenting = 1'b0; m_cfg = '0; m_pend = '0;
    reset = 1'b1;
    @(posedge CK_t);
    #1;

    // 1: reset state, single RD, busy falls after the handshake
    reset = 1'b0;
    #1;
    check("t1_ready", bus.req_ready, 1'b1);
    check("t1_valid", bus.out_valid, 1'b0);
    check("t1_count", count, 0);
    check("t1_rd_lat", rd_lat, 9);
    check("t1_wr_lat", wr_lat, 9);
    push_req(3'd1, '{bg: 2'd0, ba: 2'd1, row: 16'h12, col: 10'h8}, '0);
    check("t1_valid_c2", bus.out_valid, 1'b1);
    check("t1_req", bus.out_request, RD);
    check("t1_addr", bus.out_addr, {2'd0, 2'd1, 16'h12, 10'h8});
    check("t1_busy", busy, 1'b1);
    bus.cmd_rdy = 1'b1;
    step();
    check("t1_busy_done", busy, 1'b0);
    bus.cmd_rdy = 1'b0;

    // 2: fill to DEPTH with WRs, hold a ninth, then drain in order
    for (int i = 0; i < 9; i++) begin
      d[i] = rand_data();
      a[i] = rand_addr();
    end
    for (int i = 0; i < 8; i++) push_req(3'd2, a[i], d[i]);
    check("t2_count", count, 8);
    check("t2_ready", bus.req_ready, 1'b0);
    bus.request = 3'd2; bus.log_addr = a[8]; bus.wr_data = d[8];
    step();
    step();
    check("t2_count_held", count, 8);
    bus.cmd_rdy = 1'b1;
    k = 0; held = 1'b1;
    for (int c = 0; c < 40 && k < 9; c++) begin
      take = held && bus.req_ready;
      if (bus.out_valid) begin
        check("t2_data", bus.out_wr_data, d[k]);
        k++;
      end
      step();
      if (take) begin
        bus.request = 3'd0;
        held = 1'b0;
      end
    end
    check("t2_issued", k, 9);
    bus.cmd_rdy = 1'b0;

    // 3: two RDs then an MRS; RL/WL follow the new config
    push_req(3'd1, rand_addr(), '0);
    push_req(3'd1, rand_addr(), '0);
    set_cfg(3'd3, 3'd2, 2'd1, 1'b0, 1'b0);
    mrs_update = 1'b1;
    step();
    mrs_update = 1'b0;
    bus.cmd_rdy = 1'b1;
    ord = '0; n_iss = 0;
    for (int c = 0; c < 30 && busy; c++) begin
      if (bus.out_valid) begin
        ord = {ord[5:0], 3'(bus.out_request)};
        n_iss++;
      end
      step();
    end
    check("t3_issue_cnt", n_iss, 3);
    check("t3_order", ord, 9'b001_001_011);
    check("t3_rd_lat", rd_lat, 23);
    check("t3_wr_lat", wr_lat, 22);
    bus.cmd_rdy = 1'b0;

    // 4: a second update during DRAIN overrides the first, one MRS only
    push_req(3'd1, rand_addr(), '0);
    set_cfg(3'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    mrs_update = 1'b1;
    step();
    set_cfg(3'd7, 3'd0, 2'd0, 1'b0, 1'b0);
    step();
    mrs_update = 1'b0;
    bus.cmd_rdy = 1'b1;
    n_mrs = 0;
    for (int c = 0; c < 30 && busy; c++) begin
      if (bus.out_valid && bus.out_request == MRS) n_mrs++;
      step();
    end
    check("t4_mrs_cnt", n_mrs, 1);
    check("t4_cfg_cl", cfg_CL, 3'd7);
    check("t4_rd_lat", rd_lat, 16);

    // 5: 2tCK preambles add one cycle to each latency
    set_cfg(3'd0, 3'd0, 2'd0, 1'b1, 1'b1);
    mrs_update = 1'b1;
    step();
    mrs_update = 1'b0;
    for (int c = 0; c < 20 && busy; c++) step();
    check("t5_busy", busy, 1'b0);
    check("t5_rd_lat", rd_lat, 10);
    check("t5_wr_lat", wr_lat, 10);
    bus.cmd_rdy = 1'b0;

    // 6: reset with queued entries and a pending MRS discards everything
    for (int i = 0; i < 5; i++) push_req(3'd1, rand_addr(), '0);
    set_cfg(3'd5, 3'd4, 2'd2, 1'b1, 1'b0);
    mrs_update = 1'b1;
    step();
    mrs_update = 1'b0;
    check("t6_count_pre", count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_valid", bus.out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_cfg", {cfg_CL, cfg_BL, cfg_CWL, cfg_AL, cfg_RD_PRE, cfg_WR_PRE}, 0);
    check("t6_rd_lat", rd_lat, 9);
    check("t6_wr_lat", wr_lat, 9);

    // Randomized traffic with alternating back-pressure phases
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      if (r < 3)      bus.request = 3'd0;
      else if (r < 6) bus.request = 3'd1;
      else if (r < 9) bus.request = 3'd2;
      else            bus.request = 3'($urandom_range(3, 7));
      bus.log_addr = rand_addr();
      bus.wr_data  = rand_data();
      bus.cmd_rdy  = ($urandom_range(0, 99) < (((c / 200) % 2) != 0 ? 20 : 70));
      mrs_update   = ($urandom_range(0, 39) == 0);
      {CL, BL, CWL, AL, RD_PRE, WR_PRE} = 13'($urandom);
      step();
    end

    idle_in();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
